rr_arbiter: RTL and testbench
=============================

# rr_arbiter

Parameterised round-robin arbiter that picks one of `N` requesters per cycle and presents a strictly one-hot grant to a single downstream consumer through a valid/ready handshake. It is the producer side of the one-hot grant vectors used across the core: issue-port selection, CDB write-back arbitration and shared-port access. A grant stalled by the consumer is locked until accepted. Fairness comes from a registered rotating priority pointer.

## Interface
- `N`, 8: number of requesters; legal range 2..64, need not be a power of two.
- `IDX_W`, `$clog2(N)`: index width; derived, never overridden.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input N: per-requester request; bit i high means requester i wants the resource.
- `gnt` output N: one-hot grant, or all-zero when no grant is offered.
- `gnt_idx` output IDX_W: binary index of the granted requester; 0 when `gnt_vld` is low.
- `gnt_vld` output 1: a grant is offered this cycle.
- `gnt_rdy` input 1: consumer accepts the offered grant.

## Operation
- State: `ptr` (IDX_W, highest-priority index), `lock` (1), `lock_idx` (IDX_W).
- Unlocked (`lock`=0):
  - The grant goes to the first set `req` bit searched from `ptr` upward, wrapping N-1 → 0.
  - The pick is combinational from `req` and `ptr`.
  - `gnt_vld` = |`req`.
- Locked (`lock`=1):
  - `gnt` = onehot(`lock_idx`), `gnt_idx` = `lock_idx`, and `gnt_vld` = 1, regardless of `req`.
- Accept (`gnt_vld` & `gnt_rdy`):
  - `ptr` ← `gnt_idx`+1, or 0 if `gnt_idx` = N-1.
  - `lock` ← 0.
- Stall (`gnt_vld` & ~`gnt_rdy`):
  - `lock` ← 1, `lock_idx` ← `gnt_idx`.
  - `ptr` is unchanged.
- Idle (`gnt_vld`=0): all state holds.
- Requester rule: a requester holding a stalled grant keeps `req` high until acceptance. Dropping it is a protocol violation (see Configuration). The grant still holds.
- Invariant: `gnt` is one-hot when `gnt_vld`=1 and all-zero when `gnt_vld`=0. `gnt_idx` always encodes `gnt`.
- Wrap arithmetic is an explicit compare against N-1, never a modulo on IDX_W bits. This keeps non-power-of-two N correct.
- With a single persistent requester, that requester is granted every accepted cycle.

## Timing
- Reset values: `ptr`=0, `lock`=0, `lock_idx`=0. Therefore `gnt`=0, `gnt_idx`=0, `gnt_vld`=0 while `req`=0.
- Latency: zero cycles from `req` to `gnt` when unlocked (combinational path). State updates on the clock edge after the handshake.
- Fairness: with all N requesting and `gnt_rdy` held high, each requester is granted exactly once per N consecutive cycles.
- `gnt_rdy` may be asserted with `gnt_vld` low; it is ignored.
- Consumer rule: `gnt_rdy` may depend combinationally on `gnt_vld`/`gnt_idx`. Combinational paths `req` → `gnt_rdy` → `req` are forbidden.
- Reset asserted mid-lock:
  - `lock` clears and `ptr` returns to 0 immediately (asynchronously).
  - After release, the first grant is the lowest set `req` index.

## Configuration
- `RR_ARBITER_ASSERT_EN` defined: inline concurrent assertions, disabled during reset:
  - `gnt_vld` |-> $onehot(`gnt`).
  - ~`gnt_vld` |-> `gnt`==0.
  - `lock` |-> `req`[`lock_idx`] (requester-hold rule).
  - `gnt`[`gnt_idx`]==`gnt_vld`.
  - Each failure calls `$error` with an instance-identifying message.
- Undefined: no assertion logic. Functional behaviour is identical.

## Structure
- Shared package `arb_pkg`: the `onehot_to_idx`/`idx_to_onehot` functions and a `next_idx(idx, n)` wrap helper. These are reused by other arbiters.
- One natural sub-module: `rr_pick`, a combinational rotate-priority picker. It takes `req` and `ptr` and returns the one-hot grant and its index, implemented as a masked/unmasked double priority search.
- The top level holds the state registers, lock muxing and assertions.

## Test plan
- Reset, then `req`=4'b0000 with N=4 → `gnt_vld`=0, `gnt`=0, `gnt_idx`=0. Next `req`=4'b1010 → `gnt`=4'b0010, `gnt_idx`=1.
- N=4, `req`=4'b1111, `gnt_rdy`=1 for 8 cycles → grant order 0,1,2,3,0,1,2,3.
- `ptr`=3 after granting 2, then `req`=4'b1001 → grant 3, then 0 (wrap-around).
- Grant 2 offered with `gnt_rdy`=0 for 3 cycles while `req` changes to 4'b0111 → `gnt_idx` stays 2. On the accept cycle, the next grant is 0.
- N=5 (non-power-of-two), `req`=5'b10001, always ready → grant alternates 4,0,4,0. `ptr` never reaches 5.
- `rst_n` pulsed low while locked on index 3 → `lock` clears and `ptr`=0. After release, `req`=4'b1100 grants 2. With `RR_ARBITER_ASSERT_EN`, dropping `req`[2] during a stall raises `$error`.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared arbiter helpers: one-hot/index conversion, wrap-safe index increment,
// and the grant-lock state encoding. Sized for the widest arbiter (64 requesters);
// callers cast to their own widths.
package arb_pkg;

    localparam int MAX_N     = 64;
    localparam int MAX_IDX_W = 6;

    // OPEN: grant follows the live pick; LOCKED: a stalled grant is held
    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic logic [MAX_N-1:0] idx_to_onehot(input logic [MAX_IDX_W-1:0] idx);
        return MAX_N'(1) << idx;
    endfunction

    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_N; i++)
            if (oh[i]) idx = idx | MAX_IDX_W'(i);
        return idx;
    endfunction

    // Explicit compare against n-1 so non-power-of-two n never lands on n
    function automatic logic [MAX_IDX_W-1:0] next_idx(input logic [MAX_IDX_W-1:0] idx, input int n);
        return (int'(idx) == n - 1) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter_if.sv
// Request / grant handshake bundle between requesters+consumer and rr_arbiter.
interface rr_arbiter_if #(parameter int N = 8);

    localparam int IDX_W = $clog2(N);

    logic [N-1:0]     req;
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic             gnt_rdy;

    modport slave  (input req, gnt_rdy, output gnt, gnt_idx, gnt_vld);
    modport master (output req, gnt_rdy, input gnt, gnt_idx, gnt_vld);

endinterface

// File: rtl/rr_arbiter_pick.sv
// Combinational rotate-priority picker: first set req bit at or above ptr,
// else the lowest set req bit overall (masked/unmasked double search).
module rr_arbiter_pick
    import arb_pkg::*;
#(
    parameter  int N     = 8,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     pick_gnt,
    output logic [IDX_W-1:0] pick_idx,
    output logic             pick_vld
);

    logic [N-1:0] masked;
    logic [N-1:0] m_oh;
    logic [N-1:0] u_oh;

    // Isolate lowest set bit (x & -x) in both the masked and raw request vectors
    always_comb begin
        masked   = req & ({N{1'b1}} << ptr);
        m_oh     = masked & (-masked);
        u_oh     = req & (-req);
        pick_gnt = (|masked) ? m_oh : u_oh;
        pick_idx = IDX_W'(onehot_to_idx(MAX_N'(pick_gnt)));
        pick_vld = |req;
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with valid/ready grant handshake. A stalled grant is
// locked until accepted; priority pointer rotates past each accepted grant.
// Define RR_ARBITER_ASSERT_EN to build in protocol/invariant assertions.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter  int N     = 8,
    localparam int IDX_W = $clog2(N)
) (
    input  logic        clk,
    input  logic        rst_n,
    rr_arbiter_if.slave bus
);

    arb_state_e       state_q, state_d;
    logic             lock;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] lock_idx;

    logic [N-1:0]     pick_gnt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_vld;

    rr_arbiter_pick #(.N(N)) u_pick (
        .req      (bus.req),
        .ptr      (ptr),
        .pick_gnt (pick_gnt),
        .pick_idx (pick_idx),
        .pick_vld (pick_vld)
    );

    // Lock state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ARB_OPEN;
        else        state_q <= state_d;
    end

    // Lock on an offered-but-stalled grant, release on accept
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_OPEN:   if (pick_vld && !bus.gnt_rdy) state_d = ARB_LOCKED;
            ARB_LOCKED: if (bus.gnt_rdy)              state_d = ARB_OPEN;
            default:    state_d = ARB_OPEN;
        endcase
    end

    // Grant outputs: held index while locked, live pick otherwise
    always_comb begin
        lock        = (state_q == ARB_LOCKED);
        bus.gnt_vld = lock | pick_vld;
        bus.gnt_idx = lock ? lock_idx : pick_idx;
        bus.gnt     = lock ? N'(idx_to_onehot(MAX_IDX_W'(lock_idx))) : pick_gnt;
    end

    // Pointer advances past an accepted grant; stalled index is captured
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            lock_idx <= '0;
        end else if (bus.gnt_vld && bus.gnt_rdy) begin
            ptr      <= IDX_W'(next_idx(MAX_IDX_W'(bus.gnt_idx), N));
        end else if (bus.gnt_vld) begin
            lock_idx <= bus.gnt_idx;
        end
    end

`ifdef RR_ARBITER_ASSERT_EN
    a_vld_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        bus.gnt_vld |-> $onehot(bus.gnt))
        else $error("%m: gnt not one-hot while gnt_vld");
    a_idle_zero: assert property (@(posedge clk) disable iff (!rst_n)
        !bus.gnt_vld |-> (bus.gnt == '0))
        else $error("%m: gnt nonzero while gnt_vld low");
    a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
        lock |-> bus.req[lock_idx])
        else $error("%m: requester dropped req while its grant was stalled");
    a_idx_match: assert property (@(posedge clk) disable iff (!rst_n)
        bus.gnt[bus.gnt_idx] == bus.gnt_vld)
        else $error("%m: gnt_idx does not encode gnt");
`else
    // Checkers compiled out; datapath is unaffected.
`endif

endmodule

// File: tb/tb_rr_arbiter.sv
// Randomized + directed bench for rr_arbiter at N=4 and N=5 against a
// search-from-pointer reference model.
module tb_rr_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rr_arbiter_if #(.N(4)) b4 ();
    rr_arbiter_if #(.N(5)) b5 ();

    rr_arbiter #(.N(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
    rr_arbiter #(.N(5)) u5 (.clk(clk), .rst_n(rst_n), .bus(b5.slave));

    int total = 0;
    int bad   = 0;

    // reference model state: pointer and held (stalled) index, -1 = none
    int m_ptr  [2];
    int m_held [2];
    int nn     [2] = '{4, 5};

    logic [7:0] rq [2];
    logic       rd [2];
    int         obs4, obs5;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input int d, input logic [7:0] r);
        if (m_held[d] >= 0) return m_held[d];
        for (int k = 0; k < nn[d]; k++) begin
            int j;
            j = (m_ptr[d] + k) % nn[d];
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic mreset();
        for (int d = 0; d < 2; d++) begin
            m_ptr[d]  = 0;
            m_held[d] = -1;
        end
    endtask

    task automatic apply();
        b4.req     = rq[0][3:0];
        b4.gnt_rdy = rd[0];
        b5.req     = rq[1][4:0];
        b5.gnt_rdy = rd[1];
    endtask

    task automatic check_dut(input string tag, input int e, input logic v, input logic [63:0] idx,
                             input logic [63:0] g, input logic [63:0] p, input int mp);
        chk({tag, " vld"}, 64'(v), 64'(e >= 0));
        chk({tag, " idx"}, idx, (e >= 0) ? 64'(e) : 64'd0);
        chk({tag, " gnt"}, g, (e >= 0) ? (64'd1 << e) : 64'd0);
        chk({tag, " ptr"}, p, 64'(mp));
    endtask

    // one cycle: drive at negedge, check just after, update model at posedge
    task automatic step(input string tag);
        int e0, e1;
        apply();
        #1;
        e0 = pick(0, rq[0]);
        e1 = pick(1, rq[1]);
        check_dut({tag, "/n4"}, e0, b4.gnt_vld, 64'(b4.gnt_idx), 64'(b4.gnt), 64'(u4.ptr), m_ptr[0]);
        check_dut({tag, "/n5"}, e1, b5.gnt_vld, 64'(b5.gnt_idx), 64'(b5.gnt), 64'(u5.ptr), m_ptr[1]);
        obs4 = int'(b4.gnt_idx);
        obs5 = int'(b5.gnt_idx);
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            int e;
            e = (d == 0) ? e0 : e1;
            if (e >= 0 && rd[d]) begin
                m_ptr[d]  = (e + 1) % nn[d];
                m_held[d] = -1;
            end else if (e >= 0) begin
                m_held[d] = e;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rq[0] = '0; rq[1] = '0; rd[0] = 1'b0; rd[1] = 1'b0;
        apply();
        mreset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        rq[0] = '0; rq[1] = '0; rd[0] = 1'b0; rd[1] = 1'b0;
        apply();
        mreset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // reset state, rdy high with nothing requested is ignored
        rd[0] = 1'b1;
        step("reset");
        chk("rst gnt_vld", 64'(b4.gnt_vld), 64'd0);
        chk("rst gnt_idx", 64'(obs4), 64'd0);

        rq[0] = 8'b1010;
        step("first");
        chk("first idx", 64'(obs4), 64'd1);

        // full request fairness at N=4; two-requester alternation at N=5
        do_reset();
        rq[0] = 8'b1111; rd[0] = 1'b1;
        rq[1] = 8'b10001; rd[1] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step("fair");
            chk("fair order", 64'(obs4), 64'(k % 4));
            chk("alt5 order", 64'(obs5), (k % 2) ? 64'd4 : 64'd0);
        end
        rq[1] = '0;

        // wrap-around: grant 2 leaves ptr=3, then 1001 -> 3 then 0
        rq[0] = 8'b0100;
        step("pre-wrap");
        rq[0] = 8'b1001;
        step("wrap");
        chk("wrap first", 64'(obs4), 64'd3);
        step("wrap");
        chk("wrap second", 64'(obs4), 64'd0);

        // stall on 2 while other requests change, then accept
        rq[0] = 8'b0100; rd[0] = 1'b0;
        step("stall");
        rq[0] = 8'b0111;
        for (int k = 0; k < 2; k++) begin
            step("stall");
            chk("stall hold", 64'(obs4), 64'd2);
        end
        rd[0] = 1'b1;
        step("accept");
        chk("accept idx", 64'(obs4), 64'd2);
        step("after");
        chk("after accept", 64'(obs4), 64'd0);

        // async reset while locked on 3
        rq[0] = 8'b1000; rd[0] = 1'b0;
        step("lock3");
        step("lock3");
        rst_n = 1'b0;
        rq[0] = 8'b1100;
        apply();
        mreset();
        #1;
        chk("rst lock", 64'(u4.lock), 64'd0);
        chk("rst ptr", 64'(u4.ptr), 64'd0);
        chk("rst live idx", 64'(b4.gnt_idx), 64'd2);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step("post-rst");
        chk("post-rst idx", 64'(obs4), 64'd2);

        // randomized traffic, honouring the hold rule on stalled grants
        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < 2; d++) begin
                logic [7:0] r;
                r = 8'($urandom) & ((8'd1 << nn[d]) - 8'd1);
                if ($urandom_range(0, 7) == 0) r = '0;
                if (m_held[d] >= 0) r[m_held[d]] = 1'b1;
                rq[d] = r;
                rd[d] = ($urandom_range(0, 3) != 0);
            end
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
